sift_matvec_sched: RTL

Sequencer that evaluates a signed 3x3 matrix times a 3x1 vector, such as the inverse-Hessian × gradient product for SIFT sub-pixel keypoint refinement. It uses one shared pipelined 3-term dot-product unit, time-multiplexed over the three matrix rows. It sits between the keypoint-candidate stage, which supplies matrix and vector, and the offset/contrast stage, which consumes the 3-element result. Ready/valid handshakes are used on both sides.

---
 rtl/sift_pkg.sv | 40 ++++
 rtl/sift_matvec_sched_dot3.sv | 50 +++++
 rtl/sift_matvec_sched.sv | 124 ++++++++++++
 3 files changed

// File: rtl/sift_pkg.sv
// Shared types and helpers for the SIFT 3x3 matrix-vector scheduler:
// default widths, FSM states, matrix element indexing and result saturation.
package sift_pkg;

   localparam int DW_DEF = 9;
   localparam int OW_DEF = 19;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      HOLD  = 2'd3
   } sched_state_e;

   // Row-major element index into the captured matrix: m[row][col].
   function automatic logic [3:0] elem_idx(input logic [1:0] row, input logic [1:0] col);
      return 4'(row) * 4'd3 + 4'(col);
   endfunction

   function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] sum, input int ow);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (ow - 1));
      if (sum > hi)
         return hi;
      else if (sum < lo)
         return lo;
      return sum;
   endfunction

   function automatic logic sat_flag(input logic signed [63:0] sum, input int ow);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (ow - 1));
      return (sum > hi) || (sum < lo);
   endfunction

endpackage

// File: rtl/sift_matvec_sched_dot3.sv
// Two-stage pipelined signed 3-term dot product: registered products, then
// registered full-precision sum. No handshake; the caller tracks validity.
module sift_dot3_pipe
   import sift_pkg::*;
#(
   parameter int DW = DW_DEF
) (
   input  logic                  iclk,
   input  logic                  irst,
   input  logic signed [DW-1:0]  ia0,
   input  logic signed [DW-1:0]  ib0,
   input  logic signed [DW-1:0]  ia1,
   input  logic signed [DW-1:0]  ib1,
   input  logic signed [DW-1:0]  ia2,
   input  logic signed [DW-1:0]  ib2,
   output logic signed [2*DW+1:0] osum
);

   localparam int PW = 2 * DW;
   localparam int SW = 2 * DW + 2;

   logic signed [PW-1:0] prod0_p1;
   logic signed [PW-1:0] prod1_p1;
   logic signed [PW-1:0] prod2_p1;
   logic signed [SW-1:0] sum_p2;

   // p0 -> p1: operands widened before multiplying so -256 * -256 cannot wrap
   always_ff @(posedge iclk) begin
      if (irst) begin
         prod0_p1 <= '0;
         prod1_p1 <= '0;
         prod2_p1 <= '0;
      end else begin
         prod0_p1 <= PW'(ia0) * PW'(ib0);
         prod1_p1 <= PW'(ia1) * PW'(ib1);
         prod2_p1 <= PW'(ia2) * PW'(ib2);
      end
   end

   // p1 -> p2
   always_ff @(posedge iclk) begin
      if (irst)
         sum_p2 <= '0;
      else
         sum_p2 <= SW'(prod0_p1) + SW'(prod1_p1) + SW'(prod2_p1);
   end

   assign osum = sum_p2;

endmodule

// File: rtl/sift_matvec_sched.sv
// Sequencer for r = M * v (3x3 signed), time-multiplexing one pipelined
// dot-product unit across the three matrix rows, ready/valid on both sides.
module sift_matvec_sched
   import sift_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int OW = OW_DEF
) (
   input  logic              iclk,
   input  logic              irst,
   input  logic              ivalid,
   output logic              oready,
   input  logic [9*DW-1:0]   iData_m,
   input  logic [3*DW-1:0]   iData_v,
   output logic              ovalid,
   input  logic              iready,
   output logic [3*OW-1:0]   odata,
   output logic [2:0]        osat
);

   localparam int SW = 2 * DW + 2;

   sched_state_e state_q, state_d;

   logic signed [DW-1:0] m_q [9];
   logic signed [DW-1:0] v_q [3];
   logic [1:0]           cnt_q;
   logic [1:0]           wcnt_q;
   logic                 vld_p0;
   logic                 vld_p1;
   logic                 vld_p2;
   logic signed [OW-1:0] res_q [3];
   logic [2:0]           sat_q;

   logic                 accept;
   logic signed [DW-1:0] row_a [3];
   logic signed [SW-1:0] dot_sum;
   logic signed [OW-1:0] val_now;
   logic                 sat_now;

   assign oready = (state_q == IDLE) && !irst;
   assign ovalid = (state_q == HOLD);
   assign accept = ivalid && oready;
   assign vld_p0 = (state_q == ISSUE);

   always_comb begin
      for (int j = 0; j < 3; j++)
         row_a[j] = m_q[elem_idx(cnt_q, 2'(j))];
   end

   sift_dot3_pipe #(
      .DW (DW)
   ) u_dot (
      .iclk (iclk),
      .irst (irst),
      .ia0  (row_a[0]),
      .ib0  (v_q[0]),
      .ia1  (row_a[1]),
      .ib1  (v_q[1]),
      .ia2  (row_a[2]),
      .ib2  (v_q[2]),
      .osum (dot_sum)
   );

   always_comb begin
      val_now = OW'(sat_clamp(64'(dot_sum), OW));
      sat_now = sat_flag(64'(dot_sum), OW);
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = ISSUE;
         ISSUE:   if (cnt_q == 2'd2) state_d = DRAIN;
         DRAIN:   if (vld_p2 && (wcnt_q == 2'd2)) state_d = HOLD;
         HOLD:    if (iready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Operand capture on job acceptance
   always_ff @(posedge iclk) begin
      if (accept) begin
         for (int k = 0; k < 9; k++)
            m_q[k] <= iData_m[k*DW +: DW];
         for (int k = 0; k < 3; k++)
            v_q[k] <= iData_v[k*DW +: DW];
      end
   end

   // Control and result registers; the valid shift register follows the dot pipe
   always_ff @(posedge iclk) begin
      if (irst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         wcnt_q  <= '0;
         vld_p1  <= 1'b0;
         vld_p2  <= 1'b0;
         sat_q   <= '0;
         for (int k = 0; k < 3; k++)
            res_q[k] <= '0;
      end else begin
         state_q <= state_d;
         vld_p1  <= vld_p0;
         vld_p2  <= vld_p1;
         if (accept) begin
            cnt_q  <= '0;
            wcnt_q <= '0;
         end else begin
            if (vld_p0)
               cnt_q <= (cnt_q == 2'd2) ? 2'd0 : cnt_q + 2'd1;
            if (vld_p2) begin
               res_q[wcnt_q] <= val_now;
               sat_q[wcnt_q] <= sat_now;
               wcnt_q        <= (wcnt_q == 2'd2) ? 2'd0 : wcnt_q + 2'd1;
            end
         end
      end
   end

   assign odata = {res_q[2], res_q[1], res_q[0]};
   assign osat  = sat_q;

endmodule
